// File: rtl/dct_pkg.sv
// Shared widths, sample/coefficient types and the transform sign helper
// for the 4-point streaming transform controller.
package dct_pkg;

  localparam int DCT_N = 4;
  localparam int DT_W  = 8;
  localparam int DIR_W = 10;
  localparam int INV_W = 13;

  typedef logic signed [DT_W-1:0]  dt_t;
  typedef logic signed [DIR_W-1:0] dir_t;
  typedef logic signed [INV_W-1:0] inv_t;

  typedef dt_t  dt_vec_t  [DCT_N];
  typedef dir_t dir_vec_t [DCT_N];
  typedef inv_t inv_vec_t [DCT_N];

  // Sign of the 4-point Walsh-Hadamard kernel entry (row j, column k): 1 means negative.
  function automatic logic h_neg(input logic [1:0] j, input logic [1:0] k);
    return ^(j & k);
  endfunction

endpackage

// File: rtl/dct_stream_ctrl_if.sv
// Sample input stream and coefficient/reconstruction output stream of the
// transform controller; master is the traffic source/sink, slave the controller.
interface dct_stream_ctrl_if
  import dct_pkg::*;
();

  logic  in_valid_i;
  logic  in_ready_o;
  dt_t   in_data_i;

  logic  out_valid_o;
  logic  out_ready_i;
  dir_t  out_dir_o;
  inv_t  out_inv_o;
  logic [1:0] out_idx_o;
  logic  out_last_o;

  modport master (
    output in_valid_i,
    output in_data_i,
    input  in_ready_o,
    input  out_valid_o,
    output out_ready_i,
    input  out_dir_o,
    input  out_inv_o,
    input  out_idx_o,
    input  out_last_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    output in_ready_o,
    output out_valid_o,
    input  out_ready_i,
    output out_dir_o,
    output out_inv_o,
    output out_idx_o,
    output out_last_o
  );

endinterface

// File: rtl/dct.sv
// Combinational 4-point transform datapath: forward Walsh-Hadamard, x2
// renormalization, inverse Walsh-Hadamard (reconstruction equals 8*x).
module dct
  import dct_pkg::*;
(
  input  dt_vec_t  x,
  output dir_vec_t y,
  output inv_vec_t z
);

  inv_vec_t ren_s;

  // Forward transform, renormalization and inverse transform.
  always_comb begin
    for (int k = 0; k < DCT_N; k++) begin
      y[k]     = '0;
      z[k]     = '0;
      ren_s[k] = '0;
    end
    for (int k = 0; k < DCT_N; k++) begin
      for (int j = 0; j < DCT_N; j++) begin
        if (h_neg(2'(j), 2'(k))) begin
          y[k] = y[k] - dir_t'(x[j]);
        end else begin
          y[k] = y[k] + dir_t'(x[j]);
        end
      end
    end
    for (int k = 0; k < DCT_N; k++) begin
      ren_s[k] = inv_t'(y[k]) <<< 1'b1;
    end
    // The kernel is symmetric and squares to 4*I, so the same sign table inverts it.
    for (int j = 0; j < DCT_N; j++) begin
      for (int k = 0; k < DCT_N; k++) begin
        if (h_neg(2'(j), 2'(k))) begin
          z[j] = z[j] - ren_s[k];
        end else begin
          z[j] = z[j] + ren_s[k];
        end
      end
    end
  end

endmodule

// File: rtl/dct_stream_ctrl.sv
// Packs signed samples into 4-sample blocks, transforms each full block and
// replays forward coefficients with reconstructed samples as a beat stream.
module dct_stream_ctrl
  import dct_pkg::*;
#(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  dct_stream_ctrl_if.slave     strm,
  output logic [BLK_CNT_W-1:0] blk_cnt_o
);

  logic [1:0]           wr_cnt_r;
  logic                 in_full_r;
  dt_vec_t              in_buf_r;
  dir_vec_t             dir_q_r;
  inv_vec_t             inv_q_r;
  logic                 out_busy_r;
  logic [1:0]           rd_idx_r;
  logic [BLK_CNT_W-1:0] blk_cnt_r;

  dir_vec_t dct_dir_s;
  inv_vec_t dct_inv_s;
  logic     accept_s;
  logic     beat_s;
  logic     drain_last_s;
  logic     xfer_s;

  dct u_dct (
    .x (in_buf_r),
    .y (dct_dir_s),
    .z (dct_inv_s)
  );

  // Handshake qualifiers; a pending block may refill the output bank on the last beat.
  always_comb begin
    accept_s     = strm.in_valid_i && !in_full_r;
    beat_s       = out_busy_r && strm.out_ready_i;
    drain_last_s = beat_s && (rd_idx_r == 2'd3);
    xfer_s       = in_full_r && (!out_busy_r || drain_last_s);
  end

  // Input bank fill: four accepts mark the block full until it is transferred.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_r  <= 2'd0;
      in_full_r <= 1'b0;
      for (int i = 0; i < DCT_N; i++) begin
        in_buf_r[i] <= '0;
      end
    end else if (flush_i) begin
      wr_cnt_r  <= 2'd0;
      in_full_r <= 1'b0;
    end else begin
      if (accept_s) begin
        in_buf_r[wr_cnt_r] <= strm.in_data_i;
        wr_cnt_r           <= wr_cnt_r + 2'd1;
        if (wr_cnt_r == 2'd3) begin
          in_full_r <= 1'b1;
        end
      end else if (xfer_s) begin
        in_full_r <= 1'b0;
      end
    end
  end

  // Output bank capture and beat sequencing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_busy_r <= 1'b0;
      rd_idx_r   <= 2'd0;
      for (int i = 0; i < DCT_N; i++) begin
        dir_q_r[i] <= '0;
        inv_q_r[i] <= '0;
      end
    end else if (flush_i) begin
      out_busy_r <= 1'b0;
      rd_idx_r   <= 2'd0;
    end else if (xfer_s) begin
      out_busy_r <= 1'b1;
      rd_idx_r   <= 2'd0;
      for (int i = 0; i < DCT_N; i++) begin
        dir_q_r[i] <= dct_dir_s[i];
        inv_q_r[i] <= dct_inv_s[i];
      end
    end else if (beat_s) begin
      rd_idx_r <= rd_idx_r + 2'd1;
      if (drain_last_s) begin
        out_busy_r <= 1'b0;
      end
    end
  end

  // Completed-block counter; flush leaves it untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_cnt_r <= '0;
    end else if (!flush_i && drain_last_s) begin
      blk_cnt_r <= blk_cnt_r + BLK_CNT_W'(1);
    end
  end

  assign strm.in_ready_o  = !in_full_r;
  assign strm.out_valid_o = out_busy_r;
  assign strm.out_dir_o   = dir_q_r[rd_idx_r];
  assign strm.out_inv_o   = inv_q_r[rd_idx_r];
  assign strm.out_idx_o   = rd_idx_r;
  assign strm.out_last_o  = (rd_idx_r == 2'd3);
  assign blk_cnt_o        = blk_cnt_r;

endmodule
